coo_edge_aggregator: RTL and testbench
======================================

Name: coo_edge_aggregator

Overview:
Controller and datapath for the GCN neighbour-aggregation stage. It walks the COO edge list using the edge index produced by the edge counter, and drives that counter's enable. For each edge it reads the (src, dst) pair from COO memory and then the transformed feature row of src. It accumulates that row element-wise into an on-chip aggregate buffer indexed by dst. The buffer is read out by the downstream activation/write-back stage after done.

Parameters:
COO_EDGES, 6, number of edges in the COO list
COO_BW, $clog2(COO_EDGES), edge index width
NUM_NODES, 6, number of graph nodes / aggregate rows
NODE_BW, $clog2(NUM_NODES), node index width
FEAT_COLS, 3, elements per feature row
DATA_W, 16, signed feature element width
ACC_W, DATA_W+COO_BW, signed accumulator element width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a pass (ignored unless IDLE)
edge_count  in  COO_BW  current edge index from edge counter
enable_edge  out  1  advance pulse to edge counter
coo_rd_en  out  1  COO memory read strobe
coo_rd_addr  out  COO_BW  COO memory address (= edge_count)
coo_src  in  NODE_BW  COO column (source node), valid cycle after coo_rd_en
coo_dst  in  NODE_BW  COO row (destination node), valid cycle after coo_rd_en
feat_rd_en  out  1  feature memory read strobe
feat_rd_addr  out  NODE_BW  feature row address (= captured src)
feat_rd_data  in  FEAT_COLS*DATA_W  packed row, element 0 in LSBs, valid cycle after feat_rd_en
agg_rd_addr  in  NODE_BW  aggregate buffer read row
agg_rd_data  out  FEAT_COLS*ACC_W  combinational read of row agg_rd_addr (zero if addr >= NUM_NODES)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of pass
idx_err  out  1  sticky: an edge had src or dst >= NUM_NODES

Behaviour:
- Reset (asynchronous, any time including mid-pass): state IDLE, all aggregate elements 0, enable_edge/coo_rd_en/feat_rd_en/done/busy/idx_err 0, captured src/dst 0.
- The edge counter is required to be at 0 when start arrives. It is guaranteed by the shared reset and by the counter's wrap after edge COO_EDGES-1.
- States: IDLE, COO_RD, FEAT_RD, ACC, DONE.
- IDLE: on start, clear all aggregate elements and idx_err, then go to COO_RD.
- COO_RD: coo_rd_en=1, coo_rd_addr=edge_count; go to FEAT_RD.
- FEAT_RD: capture coo_src/coo_dst; feat_rd_en=1, feat_rd_addr=coo_src (same cycle, direct from memory output); go to ACC.
- ACC: for each element k, agg[dst][k] += sign-extend(feat_rd_data[k]) to ACC_W. enable_edge=1 for exactly this cycle.
  - If edge_count == COO_EDGES-1, go to DONE; else go to COO_RD.
- DONE: done=1 for one cycle, then go to IDLE. busy is low from IDLE onward.
- Timing: 3 cycles per edge. done is asserted 3*COO_EDGES+1 cycles after the cycle start is sampled (19 for defaults).
- Width: ACC_W covers COO_EDGES worst-case additions, so there is no saturation and no overflow.
- Index bounds: if captured src or dst >= NUM_NODES, that edge's accumulate is suppressed, idx_err is set (sticky until next start), and enable_edge still pulses so the walk continues.
- Multiple edges into the same dst accumulate correctly. Self loops (src==dst) are normal edges.
- start while busy is ignored: no clear, no restart.
- Aggregate contents are held after DONE until the next start or reset. agg_rd_data is readable at any time; mid-pass values are partial.
- One enable_edge pulse per edge exactly: COO_EDGES pulses per pass, none outside ACC.

Test Plan:
- Reset mid-pass (during edge 2 ACC) -> all outputs 0, busy 0, agg rows read 0, no further enable_edge; subsequent start completes a normal pass.
- Defaults; edges (dst,src)=(0,1),(0,2),(1,0),(2,2),(3,4),(5,3); feat rows n: {n,-n,2n} -> after done at start+19: agg0={3,-3,6}, agg1={0,0,0}, agg2={2,-2,4}, agg3={4,-4,8}, agg4=0, agg5={3,-3,6}; exactly 6 enable_edge pulses; counter back at 0.
- All 6 edges dst=0, src=1, feat1={32767,-32768,1} -> agg0={196602,-196608,6}, no overflow at ACC_W=19.
- Edge 3 with src=7 (NUM_NODES=6) -> idx_err=1, edge 3 contributes nothing, other edges accumulate, done still at start+19; next start clears idx_err.
- start re-pulsed at cycles 5 and 10 of a pass -> ignored; results and done timing identical to a single start.
- Two back-to-back passes with different feature data -> second pass results reflect only the second data set (buffer cleared on start).

Source files
------------

// File: rtl/coo_edge_aggregator.sv
// COO edge walker for GCN neighbour aggregation.
// Sums each edge's source feature row into the destination's aggregate row.
module coo_edge_aggregator #(
    parameter int COO_EDGES = 6,
    parameter int COO_BW    = $clog2(COO_EDGES),
    parameter int NUM_NODES = 6,
    parameter int NODE_BW   = $clog2(NUM_NODES),
    parameter int FEAT_COLS = 3,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = DATA_W + COO_BW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COO_BW-1:0]          edge_count,
    output logic                       enable_edge,
    output logic                       coo_rd_en,
    output logic [COO_BW-1:0]          coo_rd_addr,
    input  logic [NODE_BW-1:0]         coo_src,
    input  logic [NODE_BW-1:0]         coo_dst,
    output logic                       feat_rd_en,
    output logic [NODE_BW-1:0]         feat_rd_addr,
    input  logic [FEAT_COLS*DATA_W-1:0] feat_rd_data,
    input  logic [NODE_BW-1:0]         agg_rd_addr,
    output logic [FEAT_COLS*ACC_W-1:0] agg_rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       idx_err
);

    typedef enum logic [2:0] {
        IDLE,
        COO_RD,
        FEAT_RD,
        ACC,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [NODE_BW-1:0] src_q;
    logic [NODE_BW-1:0] dst_q;
    logic               clear;
    logic               acc_go;
    logic               acc_we;
    logic               in_range;
    logic               last_edge;

    logic signed [ACC_W-1:0] agg [NUM_NODES][FEAT_COLS];
    logic signed [ACC_W-1:0] ext [FEAT_COLS];

    assign busy        = (state_q != IDLE);
    assign coo_rd_addr = edge_count;
    assign last_edge   = (edge_count == COO_BW'(COO_EDGES - 1));
    assign in_range    = ({1'b0, src_q} < (NODE_BW + 1)'(NUM_NODES)) &&
                         ({1'b0, dst_q} < (NODE_BW + 1)'(NUM_NODES));
    assign acc_we      = acc_go && in_range;
    // Memory output drives the feature address directly in FEAT_RD.
    assign feat_rd_addr = (state_q == FEAT_RD) ? coo_src : src_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d     = state_q;
        enable_edge = 1'b0;
        coo_rd_en   = 1'b0;
        feat_rd_en  = 1'b0;
        done        = 1'b0;
        clear       = 1'b0;
        acc_go      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = COO_RD;
                end
            end
            COO_RD: begin
                coo_rd_en = 1'b1;
                state_d   = FEAT_RD;
            end
            FEAT_RD: begin
                feat_rd_en = 1'b1;
                state_d    = ACC;
            end
            ACC: begin
                enable_edge = 1'b1;
                acc_go      = 1'b1;
                state_d     = last_edge ? DONE : COO_RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the edge endpoints as the COO read returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
        end else if (state_q == FEAT_RD) begin
            src_q <= coo_src;
            dst_q <= coo_dst;
        end
    end

    // Sticky out-of-range flag, cleared when a new pass starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_err <= 1'b0;
        end else if (clear) begin
            idx_err <= 1'b0;
        end else if (acc_go && !in_range) begin
            idx_err <= 1'b1;
        end
    end

    // Sign-extend each incoming feature element to accumulator width.
    always_comb begin
        for (int k = 0; k < FEAT_COLS; k++) begin
            ext[k] = ACC_W'($signed(feat_rd_data[k*DATA_W +: DATA_W]));
        end
    end

    // Aggregate buffer: clear on start, accumulate into the dst row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_NODES; r++) begin
                for (int k = 0; k < FEAT_COLS; k++) begin
                    agg[r][k] <= '0;
                end
            end
        end else if (clear) begin
            for (int r = 0; r < NUM_NODES; r++) begin
                for (int k = 0; k < FEAT_COLS; k++) begin
                    agg[r][k] <= '0;
                end
            end
        end else if (acc_we) begin
            for (int r = 0; r < NUM_NODES; r++) begin
                if (NODE_BW'(r) == dst_q) begin
                    for (int k = 0; k < FEAT_COLS; k++) begin
                        agg[r][k] <= agg[r][k] + ext[k];
                    end
                end
            end
        end
    end

    // Row readout; unmatched (out-of-range) addresses read as zero.
    always_comb begin
        agg_rd_data = '0;
        for (int r = 0; r < NUM_NODES; r++) begin
            if (NODE_BW'(r) == agg_rd_addr) begin
                for (int k = 0; k < FEAT_COLS; k++) begin
                    agg_rd_data[k*ACC_W +: ACC_W] = agg[r][k];
                end
            end
        end
    end

endmodule

// File: tb/tb_coo_edge_aggregator.sv
// Bench for coo_edge_aggregator: directed and random passes
// against a plain-arithmetic aggregation model.
module tb_coo_edge_aggregator;

    localparam int EDGES  = 6;
    localparam int NODES  = 6;
    localparam int COLS   = 3;
    localparam int DW     = 16;
    localparam int AW     = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        edge_count;
    logic              enable_edge;
    logic              coo_rd_en;
    logic [2:0]        coo_rd_addr;
    logic [2:0]        coo_src;
    logic [2:0]        coo_dst;
    logic              feat_rd_en;
    logic [2:0]        feat_rd_addr;
    logic [COLS*DW-1:0] feat_rd_data;
    logic [2:0]        agg_rd_addr;
    logic [COLS*AW-1:0] agg_rd_data;
    logic              busy;
    logic              done;
    logic              idx_err;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    logic [2:0]         src_m [8];
    logic [2:0]         dst_m [8];
    logic signed [DW-1:0] feat_v [8][COLS];
    longint             ref_agg [NODES][COLS];
    bit                 ref_err;

    coo_edge_aggregator dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .edge_count   (edge_count),
        .enable_edge  (enable_edge),
        .coo_rd_en    (coo_rd_en),
        .coo_rd_addr  (coo_rd_addr),
        .coo_src      (coo_src),
        .coo_dst      (coo_dst),
        .feat_rd_en   (feat_rd_en),
        .feat_rd_addr (feat_rd_addr),
        .feat_rd_data (feat_rd_data),
        .agg_rd_addr  (agg_rd_addr),
        .agg_rd_data  (agg_rd_data),
        .busy         (busy),
        .done         (done),
        .idx_err      (idx_err)
    );

    always #5 clk = ~clk;

    // Edge counter sharing the design's reset, wrapping after the last edge.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_count <= '0;
        else if (enable_edge) edge_count <= (edge_count == 3'(EDGES - 1)) ? 3'd0 : edge_count + 3'd1;
    end

    // Count every enable_edge pulse ever seen.
    always @(posedge clk) begin
        if (!reset && enable_edge) pulses <= pulses + 1;
    end

    // Synchronous COO and feature memories.
    always @(posedge clk) begin
        if (coo_rd_en) begin
            coo_src <= src_m[coo_rd_addr];
            coo_dst <= dst_m[coo_rd_addr];
        end
        if (feat_rd_en) begin
            for (int k = 0; k < COLS; k++) feat_rd_data[k*DW +: DW] <= feat_v[feat_rd_addr][k];
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compute_ref();
        ref_err = 1'b0;
        for (int r = 0; r < NODES; r++)
            for (int k = 0; k < COLS; k++) ref_agg[r][k] = 0;
        for (int e = 0; e < EDGES; e++) begin
            int s;
            int d;
            s = int'(src_m[e]);
            d = int'(dst_m[e]);
            if (s < NODES && d < NODES) begin
                for (int k = 0; k < COLS; k++) ref_agg[d][k] += longint'(feat_v[s][k]);
            end else begin
                ref_err = 1'b1;
            end
        end
    endtask

    task automatic check_agg(input string tag);
        logic signed [AW-1:0] el;
        for (int r = 0; r < 8; r++) begin
            agg_rd_addr = 3'(r);
            #1;
            for (int k = 0; k < COLS; k++) begin
                el = agg_rd_data[k*AW +: AW];
                chk($sformatf("%s agg[%0d][%0d]", tag, r, k), longint'(el),
                    (r < NODES) ? ref_agg[r][k] : 64'sd0);
            end
        end
    endtask

    task automatic set_plan_edges();
        src_m[0] = 3'd1; dst_m[0] = 3'd0;
        src_m[1] = 3'd2; dst_m[1] = 3'd0;
        src_m[2] = 3'd0; dst_m[2] = 3'd1;
        src_m[3] = 3'd2; dst_m[3] = 3'd2;
        src_m[4] = 3'd4; dst_m[4] = 3'd3;
        src_m[5] = 3'd3; dst_m[5] = 3'd5;
    endtask

    task automatic set_feat_lin(input int scale);
        for (int n = 0; n < 8; n++) begin
            feat_v[n][0] = DW'(n * scale);
            feat_v[n][1] = DW'(-n * scale);
            feat_v[n][2] = DW'(2 * n * scale);
        end
    endtask

    task automatic randomize_data();
        for (int e = 0; e < 8; e++) begin
            src_m[e] = 3'($urandom_range(0, NODES - 1));
            dst_m[e] = 3'($urandom_range(0, NODES - 1));
        end
        for (int n = 0; n < 8; n++)
            for (int k = 0; k < COLS; k++) feat_v[n][k] = DW'($urandom);
    endtask

    // One full pass: start, bounded wait for done, then check everything.
    task automatic run_pass(input bit repulse, input string tag);
        int n;
        int p0;
        int busy_cyc;
        bit seen;
        compute_ref();
        p0 = pulses;
        n = 0;
        busy_cyc = 0;
        seen = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            start = repulse && (n == 5 || n == 10);
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
        end
        chk({tag, " done_latency"}, n, 19);
        chk({tag, " busy_cycles"}, busy_cyc, 19);
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, done, 0);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " pulses"}, pulses - p0, EDGES);
        chk({tag, " counter_wrap"}, edge_count, 0);
        chk({tag, " idx_err"}, idx_err, ref_err);
        check_agg(tag);
    endtask

    initial begin
        int p0;
        logic signed [AW-1:0] el;
        reset = 1'b1;
        start = 1'b0;
        agg_rd_addr = '0;
        for (int e = 0; e < 8; e++) begin
            src_m[e] = '0;
            dst_m[e] = '0;
        end
        set_feat_lin(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst enable_edge", enable_edge, 0);
        chk("rst coo_rd_en", coo_rd_en, 0);
        chk("rst feat_rd_en", feat_rd_en, 0);
        chk("rst idx_err", idx_err, 0);
        chk("rst agg_rd_data", agg_rd_data, 0);
        reset = 1'b0;

        // Reset during ACC of edge 2.
        set_plan_edges();
        set_feat_lin(1);
        @(posedge clk);
        #1 start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        chk("mid acc_edge2", enable_edge, 1);
        agg_rd_addr = 3'd0;
        #1;
        el = agg_rd_data[0 +: AW];
        chk("mid partial agg0", longint'(el), 3);
        p0 = pulses;
        reset = 1'b1;
        #1;
        chk("mid busy", busy, 0);
        chk("mid done", done, 0);
        chk("mid enable_edge", enable_edge, 0);
        chk("mid coo_rd_en", coo_rd_en, 0);
        chk("mid feat_rd_en", feat_rd_en, 0);
        chk("mid idx_err", idx_err, 0);
        for (int r = 0; r < 8; r++) begin
            agg_rd_addr = 3'(r);
            #1;
            chk($sformatf("mid agg row%0d", r), agg_rd_data, 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid no_pulses", pulses - p0, 0);
        chk("mid counter", edge_count, 0);
        chk("mid busy_idle", busy, 0);

        // Directed plan graph.
        run_pass(1'b0, "plan");

        // Extreme values into one node, all edges.
        for (int e = 0; e < EDGES; e++) begin
            src_m[e] = 3'd1;
            dst_m[e] = 3'd0;
        end
        feat_v[1][0] = 16'sd32767;
        feat_v[1][1] = -16'sd32768;
        feat_v[1][2] = 16'sd1;
        run_pass(1'b0, "extreme");
        agg_rd_addr = 3'd0;
        #1;
        el = agg_rd_data[0 +: AW];
        chk("extreme e0 const", longint'(el), 196602);
        el = agg_rd_data[AW +: AW];
        chk("extreme e1 const", longint'(el), -196608);

        // Out-of-range source on edge 3, then a clean pass clears the flag.
        set_plan_edges();
        set_feat_lin(1);
        src_m[3] = 3'd7;
        feat_v[7][0] = 16'sd1000;
        feat_v[7][1] = 16'sd2000;
        feat_v[7][2] = -16'sd3000;
        run_pass(1'b0, "idx");
        chk("idx err_const", idx_err, 1);
        set_plan_edges();
        run_pass(1'b0, "idx_clear");

        // Start re-pulsed mid-pass.
        set_feat_lin(3);
        run_pass(1'b1, "repulse");

        // Back-to-back passes with fresh random data.
        for (int i = 0; i < 4; i++) begin
            randomize_data();
            run_pass(i[0], $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
